// File: rtl/four_bank_mem.sv
// Four-bank interleaved 16-bit memory behind the cache controller.
// It uses per-bank occupancy counters and returns read data two cycles after accept.
module four_bank_mem #(
    parameter int DEPTH_W  = 8,
    parameter int BUSY_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic        rd_valid,
    output logic [3:0]  busy,
    output logic        stall,
    output logic        err
);

    localparam int         DEPTH     = 1 << DEPTH_W;
    localparam logic [1:0] BUSY_LOAD = 2'(BUSY_CYC - 1);

    logic [15:0]        mem [4][DEPTH];
    logic [1:0]         cnt [4];
    logic [1:0]         bank;
    logic [DEPTH_W-1:0] idx;
    logic               req;
    logic               accept;
    logic [15:0]        data_p1;
    logic               vld_p1;
    // Address bits above the word index alias and are deliberately ignored.
    logic               unused_addr;

    assign bank        = addr[2:1];
    assign idx         = addr[DEPTH_W+2:3];
    assign unused_addr = ^addr;

    always_comb begin
        busy = '0;
        for (int b = 0; b < 4; b++) begin
            busy[b] = (cnt[b] != 2'd0);
        end
    end

    // err outranks stall so an illegal request never reports a conflict.
    always_comb begin
        req    = rd | wr;
        err    = (rd & wr) | (req & addr[0]);
        stall  = req & ~err & busy[bank];
        accept = req & ~err & ~stall;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                cnt[b] <= 2'd0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (accept && (bank == 2'(b))) begin
                    cnt[b] <= BUSY_LOAD;
                end else if (cnt[b] != 2'd0) begin
                    cnt[b] <= cnt[b] - 2'd1;
                end
            end
        end
    end

    // Stage 1: array access on accept.
    always_ff @(posedge clk) begin
        if (!rst && accept && wr) begin
            mem[bank][idx] <= data_in;
        end
        if (accept && rd) begin
            data_p1 <= mem[bank][idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept & rd;
        end
    end

    // Stage 2: output register, forced to zero between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            data_out <= 16'd0;
        end else begin
            rd_valid <= vld_p1;
            data_out <= vld_p1 ? data_p1 : 16'd0;
        end
    end

endmodule

// File: tb/tb_four_bank_mem.sv
// Randomized scoreboard bench for four_bank_mem.
// The reference model tracks the memory per word and each bank's last accept cycle.
module tb_four_bank_mem;

    localparam int DEPTH_W = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;
    logic [15:0] data_out;
    logic        rd_valid;
    logic [3:0]  busy;
    logic        stall;
    logic        err;

    always #5 clk = ~clk;

    four_bank_mem #(.DEPTH_W(DEPTH_W), .BUSY_CYC(4)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr(wr), .rd(rd),
        .data_out(data_out), .rd_valid(rd_valid), .busy(busy), .stall(stall), .err(err)
    );

    typedef struct {
        logic [15:0] data;
        bit          known;
        int          due;
    } exp_t;

    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    exp_t        sb[$];
    logic [15:0] ref_mem [int];
    int          last_acc [4];
    logic [3:0]  mon_busy;
    exp_t        mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Word addresses alias modulo the total number of words.
    function automatic int word_key(input logic [15:0] a);
        return (int'(a) >> 1) % (4 << DEPTH_W);
    endfunction

    // A bank is occupied during the three cycles that follow its accept cycle.
    function automatic bit ref_busy(input int b, input int c);
        return (c - last_acc[b] >= 1) && (c - last_acc[b] <= 3);
    endfunction

    function automatic logic ref_err(input logic r, input logic w, input logic [15:0] a);
        return (r & w) | ((r | w) & a[0]);
    endfunction

    task automatic do_req(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        int   tries = 0;
        bit   done = 1'b0;
        logic e_err;
        logic e_stall;
        exp_t e;
        while (!done) begin
            @(negedge clk);
            rst = 1'b0; rd = r; wr = w; addr = a; data_in = d;
            #1;
            e_err   = ref_err(r, w, a);
            e_stall = (r | w) & ~e_err & ref_busy(int'(a[2:1]), cyc);
            chk("err", err, e_err);
            chk("stall", stall, e_stall);
            if (!e_stall) begin
                if ((r | w) && !e_err) begin
                    if (w) begin
                        ref_mem[word_key(a)] = d;
                    end else begin
                        e.known = ref_mem.exists(word_key(a));
                        e.data  = e.known ? ref_mem[word_key(a)] : 16'd0;
                        e.due   = cyc + 2;
                        sb.push_back(e);
                    end
                    last_acc[int'(a[2:1])] = cyc;
                end
                done = 1'b1;
            end else if (++tries > 8) begin
                chk("stall_bound", stall, 1'b0);
                done = 1'b1;
            end
        end
    endtask

    task automatic do_reset(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        logic e_err;
        @(negedge clk);
        rst = 1'b1; rd = r; wr = w; addr = a; data_in = d;
        #1;
        e_err = ref_err(r, w, a);
        chk("rst_err", err, e_err);
        chk("rst_stall", stall, (r | w) & ~e_err & ref_busy(int'(a[2:1]), cyc));
        for (int b = 0; b < 4; b++) last_acc[b] = -100;
        sb.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_req(1'b0, 1'b0, 16'($urandom), 16'($urandom));
    endtask

    // Monitor: registered outputs sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int b = 0; b < 4; b++) mon_busy[b] = ref_busy(b, cyc);
            chk("busy", busy, mon_busy);
            if (rd_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("rd_valid_unexpected", rd_valid, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rd_latency", cyc, mon_e.due);
                    if (mon_e.known) chk("data_out", data_out, mon_e.data);
                end
            end else begin
                chk("rd_valid_low", rd_valid, 1'b0);
                chk("data_out_idle", data_out, 16'd0);
                if (sb.size() != 0 && sb[0].due <= cyc) begin
                    chk("rd_valid_missing", rd_valid, 1'b1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycle %0d: got running expected finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] a;
        int          kind;
        for (int b = 0; b < 4; b++) last_acc[b] = -100;
        rst = 1'b1; rd = 1'b1; wr = 1'b0; addr = 16'd0; data_in = 16'd0;
        @(posedge clk);
        #1 mon_en = 1'b1;
        do_reset(1'b1, 1'b0, 16'h0000, 16'h0000);
        do_reset(1'b1, 1'b0, 16'h0000, 16'h0000);

        do_req(1'b0, 1'b1, 16'h0012, 16'hBEEF);
        idle(3);
        do_req(1'b1, 1'b0, 16'h0012, 16'h0000);
        idle(4);

        do_req(1'b0, 1'b1, 16'h0040, 16'h1111);
        do_req(1'b0, 1'b1, 16'h0042, 16'h2222);
        do_req(1'b0, 1'b1, 16'h0044, 16'h3333);
        do_req(1'b0, 1'b1, 16'h0046, 16'h4444);
        do_req(1'b1, 1'b0, 16'h0040, 16'h0000);
        do_req(1'b1, 1'b0, 16'h0042, 16'h0000);
        do_req(1'b1, 1'b0, 16'h0044, 16'h0000);
        do_req(1'b1, 1'b0, 16'h0046, 16'h0000);
        idle(4);

        do_req(1'b0, 1'b1, 16'h0008, 16'h5A5A);
        idle(4);
        do_req(1'b1, 1'b0, 16'h0000, 16'h0000);
        do_req(1'b1, 1'b0, 16'h0008, 16'h0000);
        idle(4);

        do_req(1'b1, 1'b0, 16'h0012, 16'h0000);
        do_req(1'b1, 1'b0, 16'h0003, 16'h0000);
        do_req(1'b1, 1'b1, 16'h0012, 16'h0BAD);
        do_req(1'b0, 1'b1, 16'h0013, 16'hDEAD);
        idle(4);
        do_req(1'b1, 1'b0, 16'h0012, 16'h0000);
        idle(4);

        do_req(1'b1, 1'b0, 16'h0042, 16'h0000);
        do_reset(1'b0, 1'b1, 16'h0012, 16'hDEAD);
        idle(4);
        do_req(1'b1, 1'b0, 16'h0012, 16'h0000);
        idle(4);

        for (int i = 0; i < 400; i++) begin
            a    = {5'($urandom), 8'($urandom_range(0, 7)), 2'($urandom), 1'b0};
            kind = $urandom_range(0, 19);
            if ($urandom_range(0, 59) == 0) do_reset(1'($urandom), 1'b0, a, 16'($urandom));
            else if (kind <= 8)  do_req(1'b1, 1'b0, a, 16'($urandom));
            else if (kind <= 16) do_req(1'b0, 1'b1, a, 16'($urandom));
            else if (kind == 17) do_req(1'b1, 1'b1, a, 16'($urandom));
            else if (kind == 18) do_req(1'($urandom), 1'b1, a | 16'h0001, 16'($urandom));
            else                 idle(1);
        end

        idle(6);
        chk("scoreboard_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
